// File: rtl/conv_window_sched.sv
// conv_window_sched: streams SRAM samples into a sliding window for the conv array.
// Define CONV_SCHED_ZERO_PAD_EN for zero-padded ("full") convolution rows.
`ifndef WINDOW_SIZE
`define WINDOW_SIZE 3
`endif
`ifndef WEIGHT_SIZE
`define WEIGHT_SIZE 2
`endif

module conv_window_sched #(
  parameter int WINDOW_SIZE = `WINDOW_SIZE,
  parameter int WEIGHT_SIZE = `WEIGHT_SIZE,
  parameter int ADDR_W      = 16,
  parameter int LEN_W       = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic [ADDR_W-1:0]             base_addr,
  input  logic [LEN_W-1:0]              len,
  output logic                          busy,
  output logic                          done,
  output logic [LEN_W-1:0]              out_count,
  output logic                          mem_rd_en,
  output logic [ADDR_W-1:0]             mem_rd_addr,
  input  logic [31:0]                   mem_rd_data,
  output logic                          window_valid,
  output logic [WINDOW_SIZE-1:0][31:0]  window,
  input  logic                          window_stall,
  input  logic [WEIGHT_SIZE-1:0]        conv_valid
);

  localparam int CW = LEN_W + 1;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_FILL   = 3'd1;
  localparam logic [2:0] S_STREAM = 3'd2;
  localparam logic [2:0] S_DRAIN  = 3'd3;
  localparam logic [2:0] S_DONE   = 3'd4;

  localparam logic [CW-1:0] W_C       = CW'(WINDOW_SIZE);
  localparam logic [CW-1:0] FILL_LAST = CW'(WINDOW_SIZE - 2);
  localparam logic [CW-1:0] ONE_C     = CW'(1);

  logic [2:0]              state_q, state_d;
  logic [ADDR_W-1:0]       base_q;
  logic [LEN_W-1:0]        len_q;
  logic [LEN_W-1:0]        rd_idx_q;
  logic [CW-1:0]           acc_q;
  logic [CW-1:0]           tgt_q;
  logic [CW-1:0]           elast_q;
  logic                    degen_q;
  logic                    pend_q;
  logic                    skid_full_q, skid_full_d;
  logic [31:0]             skid_q;
  logic [LEN_W-1:0]        oc_q, oc_d;
  logic [WINDOW_SIZE-1:0][31:0] win_q;

  logic [CW-1:0]           e_s;
  logic                    degen_s;
  logic                    active;
  logic                    avail_mem;
  logic [31:0]             mem_word;
  logic                    avail;
  logic [31:0]             smp;
  logic                    accept;
  logic                    cnt_hit;
  logic                    rd_ok;
  logic                    unused_lanes;

  assign unused_lanes = &{1'b0, conv_valid};

`ifdef CONV_SCHED_ZERO_PAD_EN
  localparam logic [CW-1:0] P_C = CW'(WINDOW_SIZE - 1);
  logic in_data;

  assign e_s     = {1'b0, len} + CW'(2 * (WINDOW_SIZE - 1));
  assign degen_s = (len == '0);
  assign in_data = (acc_q >= P_C) && (acc_q < P_C + {1'b0, len_q});
  assign avail   = in_data ? avail_mem : 1'b1;
  assign smp     = in_data ? mem_word : 32'd0;
  // Reads may start one sample early: the zero it overlaps is consumed the same cycle.
  assign rd_ok   = acc_q >= FILL_LAST;
`else
  assign e_s     = {1'b0, len};
  assign degen_s = (e_s < W_C);
  assign avail   = avail_mem;
  assign smp     = mem_word;
  assign rd_ok   = 1'b1;
`endif

  assign busy   = (state_q != S_IDLE);
  assign done   = (state_q == S_DONE);
  assign active = (state_q == S_STREAM) ||
                  ((state_q == S_FILL) && !degen_q);

  assign avail_mem = skid_full_q | pend_q;
  assign mem_word  = skid_full_q ? skid_q :
                     pend_q      ? mem_rd_data : 32'd0;

  assign accept       = active && avail && !window_stall;
  assign window_valid = (state_q == S_STREAM) && avail;
  assign window       = {smp, win_q[WINDOW_SIZE-1:1]};

  assign mem_rd_en   = busy && (rd_idx_q < len_q) && !window_stall &&
                       !skid_full_q && rd_ok;
  assign mem_rd_addr = base_q + ADDR_W'(rd_idx_q);

  assign cnt_hit = conv_valid[WEIGHT_SIZE-1] && !window_stall &&
                   ((state_q == S_FILL) || (state_q == S_STREAM) ||
                    (state_q == S_DRAIN));
  assign oc_d      = oc_q + LEN_W'(cnt_hit);
  assign out_count = oc_q;

  // A returning word parks in the skid only when the array is stalled.
  assign skid_full_d = skid_full_q ? !accept : (pend_q && window_stall);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) state_d = S_FILL;
      end
      S_FILL: begin
        if (degen_q) state_d = S_DONE;
        else if (accept && acc_q == FILL_LAST) state_d = S_STREAM;
      end
      S_STREAM: begin
        if (accept && acc_q == elast_q) state_d = S_DRAIN;
      end
      S_DRAIN: begin
        if ({1'b0, oc_d} == tgt_q) state_d = S_DONE;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      base_q      <= '0;
      len_q       <= '0;
      rd_idx_q    <= '0;
      acc_q       <= '0;
      tgt_q       <= '0;
      elast_q     <= '0;
      degen_q     <= 1'b0;
      pend_q      <= 1'b0;
      skid_full_q <= 1'b0;
      skid_q      <= '0;
      oc_q        <= '0;
      win_q       <= '0;
    end else begin
      state_q     <= state_d;
      pend_q      <= mem_rd_en;
      skid_full_q <= skid_full_d;
      if (!skid_full_q && pend_q && window_stall) skid_q <= mem_rd_data;
      if (state_q == S_IDLE && start) begin
        base_q   <= base_addr;
        len_q    <= degen_s ? '0 : len;
        tgt_q    <= e_s - W_C + ONE_C;
        elast_q  <= e_s - ONE_C;
        degen_q  <= degen_s;
        rd_idx_q <= '0;
        acc_q    <= '0;
        oc_q     <= '0;
      end else begin
        if (mem_rd_en) rd_idx_q <= rd_idx_q + LEN_W'(1);
        if (accept) begin
          acc_q <= acc_q + ONE_C;
          win_q <= window;
        end
        oc_q <= oc_d;
      end
    end
  end

endmodule

// File: tb/tb_conv_window_sched.sv
// Directed bench for conv_window_sched: SRAM and 1-cycle array model,
// window/read/done monitor, immediate-assertion checks.
module tb_conv_window_sched;

  localparam int W  = 3;
  localparam int WS = 2;
  localparam int AW = 16;
  localparam int LW = 16;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 start;
  logic [AW-1:0]        base_addr;
  logic [LW-1:0]        len;
  logic                 busy;
  logic                 done;
  logic [LW-1:0]        out_count;
  logic                 mem_rd_en;
  logic [AW-1:0]        mem_rd_addr;
  logic [31:0]          mem_rd_data;
  logic                 window_valid;
  logic [W-1:0][31:0]   window;
  logic                 window_stall;
  logic [WS-1:0]        conv_valid;

  always #5 clk = ~clk;

  conv_window_sched #(
    .WINDOW_SIZE(W), .WEIGHT_SIZE(WS), .ADDR_W(AW), .LEN_W(LW)
  ) dut (
    .clk(clk), .rst(rst), .start(start),
    .base_addr(base_addr), .len(len),
    .busy(busy), .done(done), .out_count(out_count),
    .mem_rd_en(mem_rd_en), .mem_rd_addr(mem_rd_addr),
    .mem_rd_data(mem_rd_data),
    .window_valid(window_valid), .window(window),
    .window_stall(window_stall), .conv_valid(conv_valid)
  );

  logic [31:0] mem [0:255];
  always @(posedge clk)
    mem_rd_data <= mem_rd_en ? mem[mem_rd_addr[7:0]] : 32'hDEAD_BEEF;

  // Array: result one cycle after an accepted window, held through a stall.
  logic conv_v;
  always @(posedge clk)
    if (rst) conv_v <= 1'b0;
    else if (!window_stall) conv_v <= window_valid;
  assign conv_valid = {conv_v, 1'b1};

  int tnow = 0;
  int t0 = 0;
  always @(posedge clk) tnow <= tnow + 1;

  logic [W*32-1:0] wq[$];
  int wc[$];
  int rd_cnt, rd_stall, done_cnt, done_at, first_rd;
  int oc_hist [0:63];

  always @(negedge clk) begin
    int rel;
    rel = tnow - t0;
    if (window_valid && !window_stall) begin
      wq.push_back(window);
      wc.push_back(rel);
    end
    if (mem_rd_en) begin
      rd_cnt++;
      if (first_rd < 0) first_rd = rel;
      if (window_stall) rd_stall++;
    end
    if (done) begin
      done_cnt++;
      done_at = rel;
    end
    if (rel >= 0 && rel < 64) oc_hist[rel] = int'(out_count);
  end

  int errs = 0;
  int checks = 0;

  task automatic chk(input string tag, input logic [127:0] obs,
                     input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [W*32-1:0] mkw(input int a, input int b, input int c);
    return {c[31:0], b[31:0], a[31:0]};
  endfunction

  task automatic clear_mon();
    wq.delete();
    wc.delete();
    rd_cnt = 0;
    rd_stall = 0;
    done_cnt = 0;
    done_at = -1;
    first_rd = -1;
    for (int i = 0; i < 64; i++) oc_hist[i] = -1;
  endtask

  task automatic run_row(input int base, input int n,
                         input logic [63:0] smask, input int budget);
    clear_mon();
    @(posedge clk); #1;
    base_addr = AW'(base);
    len = LW'(n);
    start = 1'b1;
    window_stall = smask[0];
    t0 = tnow;
    for (int c = 1; c < budget; c++) begin
      @(posedge clk); #1;
      start = 1'b0;
      window_stall = (c < 64) ? smask[c] : 1'b0;
      if (done_cnt > 0 && c > done_at + 1) break;
    end
  endtask

  task automatic chk_win(input string tag, input int i,
                         input logic [W*32-1:0] exp);
    logic [W*32-1:0] obs;
    obs = (i < wq.size()) ? wq[i] : 'x;
    chk(tag, 128'(obs), 128'(exp));
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, " busy"}, 128'(busy), 128'(0));
    chk({tag, " done"}, 128'(done), 128'(0));
    chk({tag, " out_count"}, 128'(out_count), 128'(0));
    chk({tag, " rd_en"}, 128'(mem_rd_en), 128'(0));
    chk({tag, " rd_addr"}, 128'(mem_rd_addr), 128'(0));
    chk({tag, " win_valid"}, 128'(window_valid), 128'(0));
    chk({tag, " window"}, 128'(window), 128'(0));
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    base_addr = '0;
    len = '0;
    window_stall = 1'b0;
    for (int i = 0; i < 256; i++) mem[i] = 32'(i + 1000);
    for (int i = 0; i < 5; i++) mem[16 + i] = 32'(i + 1);
    mem[40] = 32'd7;
    mem[41] = 32'd8;
    clear_mon();

    repeat (2) @(posedge clk);
    #1;
    chk_reset_outs("reset");
    rst = 1'b0;

`ifdef CONV_SCHED_ZERO_PAD_EN
    run_row(40, 2, 64'h0, 40);
    chk_win("pad w0", 0, mkw(0, 0, 7));
    chk_win("pad w1", 1, mkw(0, 7, 8));
    chk_win("pad w2", 2, mkw(7, 8, 0));
    chk_win("pad w3", 3, mkw(8, 0, 0));
    chk("pad nwin", 128'(wq.size()), 128'(4));
    chk("pad rd_cnt", 128'(rd_cnt), 128'(2));
    chk("pad out_count", 128'(out_count), 128'(4));
    chk("pad done_cnt", 128'(done_cnt), 128'(1));

    run_row(40, 0, 64'h0, 20);
    chk("pad0 rd_cnt", 128'(rd_cnt), 128'(0));
    chk("pad0 done_at", 128'(done_at), 128'(2));
    chk("pad0 out_count", 128'(out_count), 128'(0));
`else
    // Unstalled row x=1..5
    run_row(16, 5, 64'h0, 40);
    chk("t1 first_rd", 128'(first_rd), 128'(1));
    chk_win("t1 w0", 0, mkw(1, 2, 3));
    chk_win("t1 w1", 1, mkw(2, 3, 4));
    chk_win("t1 w2", 2, mkw(3, 4, 5));
    chk("t1 nwin", 128'(wq.size()), 128'(3));
    chk("t1 wcyc0", 128'((wc.size() > 0) ? wc[0] : -1), 128'(4));
    chk("t1 wcyc2", 128'((wc.size() > 2) ? wc[2] : -1), 128'(6));
    chk("t1 rd_cnt", 128'(rd_cnt), 128'(5));
    chk("t1 out_count", 128'(out_count), 128'(3));
    chk("t1 done_cnt", 128'(done_cnt), 128'(1));
    chk("t1 done_at", 128'(done_at), 128'(8));
    chk("t1 busy", 128'(busy), 128'(0));

    // Stall during the first read's return
    run_row(16, 5, 64'h3C, 60);
    chk_win("t2 w0", 0, mkw(1, 2, 3));
    chk_win("t2 w1", 1, mkw(2, 3, 4));
    chk_win("t2 w2", 2, mkw(3, 4, 5));
    chk("t2 nwin", 128'(wq.size()), 128'(3));
    chk("t2 rd_in_stall", 128'(rd_stall), 128'(0));
    chk("t2 rd_cnt", 128'(rd_cnt), 128'(5));
    chk("t2 out_count", 128'(out_count), 128'(3));
    chk("t2 done_cnt", 128'(done_cnt), 128'(1));

    // Stall while a result is held on the last lane
    run_row(16, 5, 64'hE0, 60);
    chk_win("t3 w1", 1, mkw(2, 3, 4));
    chk_win("t3 w2", 2, mkw(3, 4, 5));
    chk("t3 wcyc1", 128'((wc.size() > 1) ? wc[1] : -1), 128'(8));
    chk("t3 wcyc2", 128'((wc.size() > 2) ? wc[2] : -1), 128'(10));
    chk("t3 oc@7", 128'(oc_hist[7]), 128'(0));
    chk("t3 oc@9", 128'(oc_hist[9]), 128'(1));
    chk("t3 oc@10", 128'(oc_hist[10]), 128'(2));
    chk("t3 out_count", 128'(out_count), 128'(3));
    chk("t3 done_at", 128'(done_at), 128'(12));

    // Degenerate row
    run_row(16, 2, 64'h0, 20);
    chk("t4 rd_cnt", 128'(rd_cnt), 128'(0));
    chk("t4 done_at", 128'(done_at), 128'(2));
    chk("t4 out_count", 128'(out_count), 128'(0));
    chk("t4 nwin", 128'(wq.size()), 128'(0));
    chk("t4 done_cnt", 128'(done_cnt), 128'(1));

    // Reset in the middle of STREAM, then replay the row
    clear_mon();
    @(posedge clk); #1;
    base_addr = 16'd16;
    len = 16'd5;
    start = 1'b1;
    t0 = tnow;
    for (int c = 1; c < 5; c++) begin
      @(posedge clk); #1;
      start = 1'b0;
    end
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    chk_reset_outs("t5 rst");
    run_row(16, 5, 64'h0, 40);
    chk_win("t5 w0", 0, mkw(1, 2, 3));
    chk_win("t5 w1", 1, mkw(2, 3, 4));
    chk_win("t5 w2", 2, mkw(3, 4, 5));
    chk("t5 out_count", 128'(out_count), 128'(3));
    chk("t5 done_cnt", 128'(done_cnt), 128'(1));
`endif

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
